// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, redirect flush and operand-forwarding control for the
// 5-stage core, with saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REGISTER_SIZE = 5,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [REGISTER_SIZE-1:0] dec_rs1,
    input  logic                     dec_rs1_used,
    input  logic [REGISTER_SIZE-1:0] dec_rs2,
    input  logic                     dec_rs2_used,
    input  logic [REGISTER_SIZE-1:0] dec_rd,
    input  logic                     dec_rd_write,
    input  logic                     dec_is_load,
    input  logic                     redirect,
    output logic                     f_to_d_enable,
    output logic                     d_to_e_enable,
    output logic                     d_bubble,
    output logic                     flush_fd,
    output logic [3:0]               pipeline_forward_sel,
    output logic [CNT_WIDTH-1:0]     stall_count,
    output logic [CNT_WIDTH-1:0]     flush_count
);

    typedef struct packed {
        logic                     valid;
        logic [REGISTER_SIZE-1:0] rd;
        logic                     wr;
        logic                     load;
    } shadow_t;

    localparam logic [1:0] SEL_RF      = 2'd0;
    localparam logic [1:0] SEL_MEM_DM  = 2'd1;
    localparam logic [1:0] SEL_EX_ALU  = 2'd2;
    localparam logic [1:0] SEL_MEM_ALU = 2'd3;

    shadow_t ex_q;
    shadow_t mem_q;

    logic ex_hit_a;
    logic ex_hit_b;
    logic mem_hit_a;
    logic mem_hit_b;
    logic load_use;
    logic stall;
    logic flush;

    assign ex_hit_a  = ex_q.valid & ex_q.wr & dec_rs1_used
                     & (dec_rs1 == ex_q.rd);
    assign ex_hit_b  = ex_q.valid & ex_q.wr & dec_rs2_used
                     & (dec_rs2 == ex_q.rd);
    assign mem_hit_a = mem_q.valid & mem_q.wr & dec_rs1_used
                     & (dec_rs1 == mem_q.rd);
    assign mem_hit_b = mem_q.valid & mem_q.wr & dec_rs2_used
                     & (dec_rs2 == mem_q.rd);

    assign load_use = (ex_hit_a | ex_hit_b) & ex_q.load;
    assign stall    = dec_valid & load_use;
    assign flush    = redirect & dec_valid & ~stall;

    function automatic logic [1:0] pick(input logic ex_hit,
                                        input logic mem_hit);
        logic [1:0] s;
        s = SEL_RF;
        if (ex_hit && !ex_q.load)
            s = SEL_EX_ALU;
        else if (mem_hit && mem_q.load)
            s = SEL_MEM_DM;
        else if (mem_hit)
            s = SEL_MEM_ALU;
        return s;
    endfunction

    assign pipeline_forward_sel = {pick(ex_hit_b, mem_hit_b),
                                   pick(ex_hit_a, mem_hit_a)};

    assign f_to_d_enable = ~stall;
    assign d_to_e_enable = 1'b1;
    assign d_bubble      = stall;
    assign flush_fd      = flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            mem_q <= ex_q;
            if (stall || !dec_valid) begin
                ex_q <= '0;
            end else begin
                ex_q.valid <= 1'b1;
                ex_q.rd    <= dec_rd;
                ex_q.wr    <= dec_rd_write & (dec_rd != '0);
                ex_q.load  <= dec_is_load;
            end
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
            if (flush && flush_count != '1)
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule
